// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: queues REG/MEM/ILLEGAL commit records for a valid/ready sink.
// Optional per-record cycle stamp when TRACE_CYCLE_STAMP_EN is defined.
module retire_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            retire_en,
    input  logic [31:0]     pc,
    input  logic            reg_we,
    input  logic [4:0]      rd,
    input  logic [31:0]     wb_data,
    input  logic            mem_we,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_wdata,
    output logic            t_valid,
    input  logic            t_ready,
    output logic [1:0]      t_kind,
    output logic [31:0]     t_pc,
    output logic [31:0]     t_tgt,
    output logic [31:0]     t_data,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0]     t_stamp,
`endif
    output logic [PTR_W:0]  level,
    output logic [15:0]     drop_cnt,
    output logic            err
);

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [1:0] K_REG = 2'b01;
    localparam logic [1:0] K_MEM = 2'b10;
    localparam logic [1:0] K_ILL = 2'b11;

    logic [1:0]       kind_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      tgt_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic        reg_ev;
    logic        push_req;
    logic        illegal;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic        drop;
    logic [1:0]  kind_in;
    logic [31:0] tgt_in;
    logic [31:0] data_in;

    always_comb begin
        reg_ev   = reg_we && !(DROP_X0 && (rd == 5'd0));
        push_req = retire_en && (mem_we || reg_ev);
        illegal  = retire_en && mem_we && reg_we;
        full     = (level == FULL_LVL);
        pop      = t_valid && t_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        kind_in  = K_REG;
        if (mem_we && reg_we) begin
            kind_in = K_ILL;
        end else if (mem_we) begin
            kind_in = K_MEM;
        end
        tgt_in  = mem_we ? mem_addr : {27'b0, rd};
        data_in = reg_we ? wb_data : mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                kind_q[i] <= '0;
                pc_q[i]   <= '0;
                tgt_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                kind_q[wr_ptr] <= kind_in;
                pc_q[wr_ptr]   <= pc;
                tgt_q[wr_ptr]  <= tgt_in;
                data_q[wr_ptr] <= data_in;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (drop || illegal) begin
                err <= 1'b1;
            end
        end
    end

    assign t_valid = (level != '0);
    assign t_kind  = kind_q[rd_ptr];
    assign t_pc    = pc_q[rd_ptr];
    assign t_tgt   = tgt_q[rd_ptr];
    assign t_data  = data_q[rd_ptr];

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
    logic [31:0] stamp_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            cyc <= cyc + 1'b1;
            if (push_ok) begin
                stamp_q[wr_ptr] <= cyc;
            end
        end
    end

    assign t_stamp = stamp_q[rd_ptr];
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer.
// Define TRACE_CYCLE_STAMP_EN to also check the cycle stamp.
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_en;
    logic [31:0] pc;
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        t_valid;
    logic        t_ready;
    logic [1:0]  t_kind;
    logic [31:0] t_pc;
    logic [31:0] t_tgt;
    logic [31:0] t_data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] t_stamp;
`endif
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    retire_trace_buffer dut (
        .clk(clk),
        .reset(reset),
        .retire_en(retire_en),
        .pc(pc),
        .reg_we(reg_we),
        .rd(rd),
        .wb_data(wb_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .t_valid(t_valid),
        .t_ready(t_ready),
        .t_kind(t_kind),
        .t_pc(t_pc),
        .t_tgt(t_tgt),
        .t_data(t_data),
`ifdef TRACE_CYCLE_STAMP_EN
        .t_stamp(t_stamp),
`endif
        .level(level),
        .drop_cnt(drop_cnt),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire_en = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        pc        = '0;
        rd        = '0;
        wb_data   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic reg_ev(input logic [31:0] p, input logic [4:0] r,
                          input logic [31:0] w);
        idle();
        retire_en = 1'b1;
        reg_we    = 1'b1;
        pc        = p;
        rd        = r;
        wb_data   = w;
    endtask

    task automatic mem_ev(input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] d);
        idle();
        retire_en = 1'b1;
        mem_we    = 1'b1;
        pc        = p;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    initial begin
        idle();
        reset   = 1'b0;
        t_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(t_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_kind", 32'(t_kind), 32'd0);
        chk("rst_pc", t_pc, 32'd0);
        reset = 1'b1;

        // REG record, one-cycle latency, popped next edge
        t_ready = 1'b1;
        reg_ev(32'h10, 5'd5, 32'hFFFF_FFFC);
        step();
        idle();
        chk("t1_valid", 32'(t_valid), 32'd1);
        chk("t1_kind", 32'(t_kind), 32'd1);
        chk("t1_pc", t_pc, 32'h10);
        chk("t1_tgt", t_tgt, 32'd5);
        chk("t1_data", t_data, 32'hFFFF_FFFC);
        chk("t1_level", 32'(level), 32'd1);
        step();
        chk("t1_level0", 32'(level), 32'd0);
        chk("t1_valid0", 32'(t_valid), 32'd0);

        // MEM record, then x0 write that must be discarded
        mem_ev(32'h24, 32'h200, 32'd16);
        step();
        reg_ev(32'h28, 5'd0, 32'h1234);
        chk("t2_kind", 32'(t_kind), 32'd2);
        chk("t2_pc", t_pc, 32'h24);
        chk("t2_tgt", t_tgt, 32'h200);
        chk("t2_data", t_data, 32'd16);
        step();
        idle();
        chk("t2_x0_level", 32'(level), 32'd0);
        chk("t2_x0_valid", 32'(t_valid), 32'd0);

        // retire_en low: events ignored
        idle();
        reg_we = 1'b1;
        rd     = 5'd7;
        mem_we = 1'b1;
        step();
        idle();
        chk("noret_level", 32'(level), 32'd0);
        chk("noret_err", 32'(err), 32'd0);

        // 18 pushes with back-pressure: 16 stored, 2 dropped
        t_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            reg_ev(32'h1000 + 32'(4 * i), 5'(i + 1), 32'h700 + 32'(i));
            step();
        end
        idle();
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_drop", 32'(drop_cnt), 32'd2);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_head_pc", t_pc, 32'h1000);
        step();
        chk("t3_hold_pc", t_pc, 32'h1000);
        chk("t3_hold_valid", 32'(t_valid), 32'd1);

        // full, push and pop in the same cycle
        t_ready = 1'b1;
        reg_ev(32'h2000, 5'd20, 32'hABCD);
        step();
        idle();
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_drop", 32'(drop_cnt), 32'd2);
        for (int i = 1; i < 16; i++) begin
            chk("t4_drain_pc", t_pc, 32'h1000 + 32'(4 * i));
            chk("t4_drain_tgt", t_tgt, 32'(i + 1));
            step();
        end
        chk("t4_last_pc", t_pc, 32'h2000);
        chk("t4_last_tgt", t_tgt, 32'd20);
        chk("t4_last_data", t_data, 32'hABCD);
        step();
        chk("t4_empty", 32'(level), 32'd0);

        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst2_drop", 32'(drop_cnt), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);

        // ILLEGAL record, then mid-stream reset with 5 queued
        t_ready   = 1'b0;
        idle();
        retire_en = 1'b1;
        reg_we    = 1'b1;
        mem_we    = 1'b1;
        pc        = 32'h40;
        rd        = 5'd3;
        wb_data   = 32'h55;
        mem_addr  = 32'h300;
        mem_wdata = 32'h77;
        step();
        idle();
        chk("t5_level", 32'(level), 32'd1);
        chk("t5_kind", 32'(t_kind), 32'd3);
        chk("t5_tgt", t_tgt, 32'h300);
        chk("t5_data", t_data, 32'h55);
        chk("t5_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mem_ev(32'h44 + 32'(4 * i), 32'h400, 32'(i));
            step();
        end
        idle();
        chk("t5_level5", 32'(level), 32'd5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5_rst_valid", 32'(t_valid), 32'd0);
        chk("t5_rst_level", 32'(level), 32'd0);
        chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
        chk("t5_rst_err", 32'(err), 32'd0);

`ifdef TRACE_CYCLE_STAMP_EN
        // counter is 0 after the reset edge; pushes land at counts 3,4,5
        step();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            reg_ev(32'h80 + 32'(4 * i), 5'd9, 32'(i));
            step();
        end
        idle();
        t_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_stamp", t_stamp, 32'd3 + 32'(i));
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
